// File: rtl/disk_pkg.sv
// Shared types and constants for the disk-interface UARTs.
package disk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DISK_CLKS_PER_BIT  = 868;
   localparam int DISK_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/disk_uart_tx_if.sv
// Bus-side write port and status of the disk UART transmitter.
interface disk_uart_tx_if #(
   parameter int FIFO_DEPTH = 16
);
   logic                          wr_en;
   logic [7:0]                    wr_data;
   logic                          full;
   logic                          empty;
   logic [$clog2(FIFO_DEPTH):0]   count;
   logic                          busy;
   logic                          overflow;
   logic                          TxD;

   modport master (
      output wr_en, wr_data,
      input  full, empty, count, busy, overflow, TxD
   );

   modport slave (
      input  wr_en, wr_data,
      output full, empty, count, busy, overflow, TxD
   );
endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with first-word-fall-through output and a separate
// occupancy counter so full/empty never depend on pointer comparison.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = AW'(DEPTH - 1) + 1'b1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [AW:0]      count_nxt;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + 1'b1;
      else if (!do_push && do_pop)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         empty <= (count_nxt == '0);
      end
   end

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/disk_uart_tx.sv
// Buffered 8N1 transmitter: byte FIFO feeding a registered-output serializer.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); pops the next byte on its last cycle
module disk_uart_tx
   import disk_pkg::*;
#(
   parameter int CLKS_PER_BIT = DISK_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DISK_TX_FIFO_DEPTH
) (
   input  logic           clk,
   input  logic           rst,
   disk_uart_tx_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t       state;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_reg;
   logic            txd;
   logic            overflow;
   logic            baud_last;
   logic            pop;
   logic [7:0]      fifo_dout;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.wr_en),
      .pop   (pop),
      .din   (bus.wr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_last = (baud_cnt == BAUD_LAST);
   assign pop = !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && baud_last));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         txd       <= 1'b1;
         overflow  <= 1'b0;
      end else begin
         if (bus.wr_en && fifo_full)
            overflow <= 1'b1;

         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  shift_reg <= fifo_dout;
                  txd       <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  txd      <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     // Next bit is presented from the shifted copy so txd stays a plain flop.
                     bit_idx   <= bit_idx + 1'b1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     txd       <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift_reg <= fifo_dout;
                     txd       <= 1'b0;
                     state     <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.full     = fifo_full;
   assign bus.empty    = fifo_empty;
   assign bus.count    = fifo_count;
   assign bus.busy     = (state != IDLE);
   assign bus.overflow = overflow;
   assign bus.TxD      = txd;

endmodule

// File: doc/disk_uart_tx.md
# disk_uart_tx

Buffered 8N1 UART transmitter forming the serial output stage of the disk interface. The bus-side logic pushes response and command bytes into it, and it drives `TxD` toward the host-side disk image server. A 16-entry byte FIFO decouples bus writes from the slow serial line, so `Memwrite` cycles never stall on the UART.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.
- `FIFO_DEPTH`, default 16: byte FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push `wr_data` into FIFO this cycle.
- `wr_data`  in  8  byte to transmit.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes; registered.
- `empty`  out  1  FIFO holds 0 bytes; registered.
- `count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  serializer not in IDLE.
- `overflow`  out  1  sticky; set when `wr_en` is asserted while `full`=1; cleared only by `rst`.
- `TxD`  out  1  serial line, idle high.

## Operation
- Reset values: `TxD`=1, `busy`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0, FSM=IDLE, pointers=0, bit and baud counters=0.
- Write acceptance:
  - A write is accepted iff `wr_en`=1 and `full`=0, judged on the registered `full`.
  - A write while full is dropped, sets `overflow`, and leaves FIFO contents unchanged.
- Pop: the serializer pops when it is in IDLE with `empty`=0, or on the last cycle of STOP with `empty`=0.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. The pop returns the oldest byte, never the byte being written that cycle, unless the FIFO was empty. An empty FIFO cannot pop, so the byte is written only.
- FSM states: IDLE → START → DATA → STOP → (IDLE or START).
  - IDLE: `TxD`=1. If `empty`=0, pop into `shift_reg` and go to START.
  - START: `TxD`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each bit held `CLKS_PER_BIT` cycles. `bit_idx` runs 0..7.
  - STOP: `TxD`=1 for `CLKS_PER_BIT` cycles. On its last cycle, if `empty`=0, pop and go to START with no idle gap; otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state change. A bit ends when the counter equals `CLKS_PER_BIT`-1.
- Pointers: `$clog2(FIFO_DEPTH)` bits wide, wrapping modulo depth. `count` is tracked separately, so full and empty are unambiguous.
- Reset mid-frame: `TxD` returns high the next cycle. The FIFO is emptied and the partial frame is abandoned, with no stop bit completed.

## Timing
- Write at edge N: the byte is visible in `count`/`empty` after edge N.
- Latency, idle serializer: IDLE pops at edge N+1, and `TxD` falls (start bit) after edge N+1. Write-to-start-bit latency is therefore 2 cycles.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames: zero idle cycles between the stop bit and the next start bit.
- `TxD` is driven from a register (glitch-free output).
- `busy` rises with the START entry and falls on the first IDLE cycle.

## Structure
- Package `disk_pkg`:
  - FSM state enum `tx_state_t` (IDLE, START, DATA, STOP).
  - Constants `DISK_CLKS_PER_BIT`=868 and `DISK_TX_FIFO_DEPTH`=16, shared with the future `disk_uart_rx`.
- Sub-module `byte_fifo`: synchronous FIFO with parameters `WIDTH` and `DEPTH`. Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`. `dout` is first-word-fall-through.
- `disk_uart_tx` instantiates `byte_fifo` and contains the serializer FSM plus the overflow flag.

## Test plan
Unless a scenario overrides them, use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Single byte: write 0xA5 after reset. `TxD` falls 2 cycles later, then sends the sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit; total frame 40 cycles; `busy` then drops and `empty`=1.
- Burst: write 0x11, 0x22, 0x33 on consecutive cycles. Three frames go out back-to-back with no high gap between the stop and next start bit, and `count` peaks at 2.
- Overflow:
  - Stall the serializer case: hold the FIFO at 4 entries while a frame is in flight, then write 0xFF → `overflow`=1 and `count` stays 4. 0xFF is never transmitted.
  - Subsequent normal writes are still accepted once not full.
- Simultaneous push/pop: with `count`=1 and STOP ending, write 0x5A on the pop cycle → `count` remains 1, and bytes transmit in FIFO order.
- Reset mid-DATA: assert `rst` during bit 3 of 0xC3 → `TxD`=1, `busy`=0, `count`=0, `overflow`=0 on the next cycle. A fresh write of 0x01 transmits correctly.
- Default parameters: write 0x55 with `CLKS_PER_BIT`=868 → start bit lasts exactly 868 cycles and the frame lasts 8680 cycles.
